dac1411_stream_tx: RTL and testbench

//  Transmit-side counterpart of the ADC capture path. Accepts paired 16-bit channel samples

---
 rtl/dac1411_stream_tx.sv | 173 +++++++++++++++++
 tb/tb_dac1411_stream_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dac1411_stream_tx.sv
// Paced transmit path: buffers paired channel samples in a small FIFO and drives an
// interleaved (ch1 then ch2) truncated DAC bus once per sample period.
module dac1411_stream_tx #(
  parameter int unsigned DAC_IN_DATA_SIZE  = 16,
  parameter int unsigned DAC_OUT_DATA_SIZE = 14,
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned RATE_DIV          = 10,
  parameter int unsigned SETTLE_CYCLES     = 100
) (
  input  logic                              i_sys_clock,
  input  logic                              i_reset,
  input  logic                              i_enable,
  input  logic [DAC_IN_DATA_SIZE-1:0]       i_data_ch1,
  input  logic [DAC_IN_DATA_SIZE-1:0]       i_data_ch2,
  input  logic                              i_valid,
  output logic                              o_ready,
  output logic [DAC_OUT_DATA_SIZE-1:0]      o_dac_data,
  output logic                              o_dac_sel,
  output logic                              o_dac_en,
  output logic                              o_running,
  output logic                              o_underrun,
  output logic [$clog2(FIFO_DEPTH):0]       o_fifo_level
);

  localparam int unsigned IN  = DAC_IN_DATA_SIZE;
  localparam int unsigned OUT = DAC_OUT_DATA_SIZE;
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned RCW = $clog2(RATE_DIV);
  localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t              state_q, state_d;
  logic [SCW-1:0]      settle_cnt_q;
  logic [RCW-1:0]      rate_cnt_q;
  logic [2*OUT-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       level_q, level_d;
  logic [OUT-1:0]      hold_ch1_q, hold_ch2_q;
  logic                ready_q;
  logic [OUT-1:0]      dac_data_q;
  logic                dac_sel_q;
  logic                dac_en_q;
  logic                running_q;
  logic                underrun_q;

  logic                tick;
  logic                push;
  logic                pop;
  logic                empty;
  logic                flush;
  logic [2*OUT-1:0]    head;
  logic [OUT-1:0]      ch1_src;

  // Only the upper OUT bits of each sample ever reach the bus, so only those are stored.
  if (IN > OUT) begin : g_lsb
    logic unused_lsbs;
    assign unused_lsbs = ^{i_data_ch1[IN-OUT-1:0], i_data_ch2[IN-OUT-1:0]};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_enable) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!i_enable)                                     state_d = ST_IDLE;
        else if (settle_cnt_q == SCW'(SETTLE_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN:    if (!i_enable) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    flush   = (state_d == ST_IDLE);
    tick    = (state_q == ST_RUN) && (rate_cnt_q == '0);
    empty   = (level_q == '0);
    push    = i_valid && ready_q;
    pop     = tick && !empty;
    head    = mem_q[rd_ptr_q];
    ch1_src = pop ? head[2*OUT-1:OUT] : hold_ch1_q;

    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge i_sys_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      rate_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      hold_ch1_q   <= '0;
      hold_ch2_q   <= '0;
      ready_q      <= 1'b0;
      dac_data_q   <= '0;
      dac_sel_q    <= 1'b0;
      dac_en_q     <= 1'b0;
      running_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      // Ready looks at the post-edge level so a full FIFO is never offered a push.
      ready_q <= !flush && (level_d != LW'(FIFO_DEPTH));

      if (flush) begin
        settle_cnt_q <= '0;
        rate_cnt_q   <= '0;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        dac_data_q   <= '0;
        dac_sel_q    <= 1'b0;
        dac_en_q     <= 1'b0;
        running_q    <= 1'b0;
        underrun_q   <= 1'b0;
      end else begin
        dac_en_q  <= 1'b1;
        running_q <= (state_d == ST_RUN);

        if (push) begin
          mem_q[wr_ptr_q] <= {i_data_ch1[IN-1 -: OUT], i_data_ch2[IN-1 -: OUT]};
          wr_ptr_q        <= wr_ptr_q + AW'(1);
        end

        if (pop) begin
          rd_ptr_q   <= rd_ptr_q + AW'(1);
          hold_ch1_q <= head[2*OUT-1:OUT];
          hold_ch2_q <= head[OUT-1:0];
        end

        if (state_q == ST_SETTLE) settle_cnt_q <= settle_cnt_q + SCW'(1);

        if (state_q == ST_RUN) begin
          if (rate_cnt_q == RCW'(RATE_DIV - 1)) rate_cnt_q <= '0;
          else                                  rate_cnt_q <= rate_cnt_q + RCW'(1);
        end

        // Hold regs are only refreshed by a pop, so an empty tick replays the last pair.
        if (tick) begin
          dac_data_q <= ch1_src;
          dac_sel_q  <= 1'b1;
          if (empty) underrun_q <= 1'b1;
        end else if ((state_q == ST_RUN) && (rate_cnt_q == RCW'(1))) begin
          dac_data_q <= hold_ch2_q;
          dac_sel_q  <= 1'b0;
        end
      end
    end
  end

  assign o_ready      = ready_q;
  assign o_dac_data   = dac_data_q;
  assign o_dac_sel    = dac_sel_q;
  assign o_dac_en     = dac_en_q;
  assign o_running    = running_q;
  assign o_underrun   = underrun_q;
  assign o_fifo_level = level_q;

endmodule

// File: tb/tb_dac1411_stream_tx.sv
// Directed bench for dac1411_stream_tx with a scoreboard of expected bus pairs.
module tb_dac1411_stream_tx;

  localparam int unsigned IN   = 16;
  localparam int unsigned OUT  = 14;
  localparam int unsigned DEP  = 4;
  localparam int unsigned RDIV = 10;
  localparam int unsigned SETL = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [IN-1:0]   ch1, ch2;
  logic            valid;
  logic            ready;
  logic [OUT-1:0]  dac_data;
  logic            dac_sel;
  logic            dac_en;
  logic            running;
  logic            underrun;
  logic [2:0]      level;

  int n_checks = 0;
  int n_errs   = 0;
  logic [2*OUT-1:0] sb[$];
  logic [2*OUT-1:0] last_pair = '0;

  dac1411_stream_tx #(
    .DAC_IN_DATA_SIZE (IN),
    .DAC_OUT_DATA_SIZE(OUT),
    .FIFO_DEPTH       (DEP),
    .RATE_DIV         (RDIV),
    .SETTLE_CYCLES    (SETL)
  ) dut (
    .i_sys_clock (clk),
    .i_reset     (rst),
    .i_enable    (en),
    .i_data_ch1  (ch1),
    .i_data_ch2  (ch2),
    .i_valid     (valid),
    .o_ready     (ready),
    .o_dac_data  (dac_data),
    .o_dac_sel   (dac_sel),
    .o_dac_en    (dac_en),
    .o_running   (running),
    .o_underrun  (underrun),
    .o_fifo_level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*OUT-1:0] model_pair(input logic [IN-1:0] a, input logic [IN-1:0] b);
    return {a[IN-1:IN-OUT], b[IN-1:IN-OUT]};
  endfunction

  // Holds the pair valid until accepted; waits = cycles spent with ready low.
  task automatic send(input logic [IN-1:0] a, input logic [IN-1:0] b, output int waits);
    ch1   = a;
    ch2   = b;
    valid = 1'b1;
    waits = 0;
    while (!ready && waits < 50) begin
      step();
      waits++;
    end
    chk("send_ready", ready, 1);
    if (ready) begin
      step();
      sb.push_back(model_pair(a, b));
    end
    valid = 1'b0;
  endtask

  // Waits for the ch1 slot, then checks it and the RDIV-1 ch2 cycles that follow.
  task automatic check_tick(input bit fresh, input logic exp_ur);
    int n = 0;
    step();
    while (dac_sel !== 1'b1 && n < 3 * RDIV) begin
      step();
      n++;
    end
    chk("tick_seen", dac_sel, 1);
    if (fresh) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) last_pair = sb.pop_front();
    end
    chk("ch1_slot", {dac_sel, dac_data}, {1'b1, last_pair[2*OUT-1:OUT]});
    chk("underrun", underrun, exp_ur);
    for (int i = 0; i < RDIV - 1; i++) begin
      step();
      chk("ch2_slot", {dac_sel, dac_data}, {1'b0, last_pair[OUT-1:0]});
    end
  endtask

  initial begin
    int k;
    int w;
    logic [2*OUT-1:0] p;

    rst = 1'b1; en = 1'b0; valid = 1'b1; ch1 = 16'h5555; ch2 = 16'hAAAA;
    step();
    step();
    chk("rst_data",    dac_data, 0);
    chk("rst_sel",     dac_sel, 0);
    chk("rst_en",      dac_en, 0);
    chk("rst_running", running, 0);
    chk("rst_under",   underrun, 0);
    chk("rst_ready",   ready, 0);
    chk("rst_level",   level, 0);

    rst = 1'b0; valid = 1'b0;
    step();
    chk("idle_ready", ready, 0);
    en = 1'b1;
    step();
    chk("settle_en",   dac_en, 1);
    chk("settle_data", dac_data, 0);
    chk("settle_run",  running, 0);
    chk("settle_rdy",  ready, 1);
    k = 0;
    while (!running && k < 200) begin
      step();
      k++;
    end
    chk("settle_len", k, SETL);

    // First RUN cycle is a tick with an empty FIFO: replay of the zero pair.
    check_tick(1'b0, 1'b1);

    step();
    send(16'h7FFC, 16'h8000, w);
    check_tick(1'b1, 1'b1);
    chk("c3_level", level, 0);

    step();
    send(16'h1111, 16'h2222, w);
    send(16'h3333, 16'h4444, w);
    send(16'h8001, 16'h7FFF, w);
    send(16'hFFFF, 16'h0003, w);
    chk("full_level", level, 4);
    chk("full_ready", ready, 0);
    send(16'h1234, 16'hFFFC, w);
    chk("fifth_wait", w, 6);
    chk("fifth_level", level, 4);
    p = sb.pop_front();
    chk("pop_ch2", {dac_sel, dac_data}, {1'b0, p[OUT-1:0]});
    for (int i = 0; i < 4; i++) check_tick(1'b1, 1'b1);
    chk("drain_level", level, 0);

    step();
    send(16'h0100, 16'h0200, w);
    send(16'h0300, 16'h0400, w);
    send(16'h0500, 16'h0600, w);
    chk("pre_drop_level", level, 3);
    chk("pre_drop_ur",    underrun, 1);
    en = 1'b0; valid = 1'b1; ch1 = 16'h7777; ch2 = 16'h6666;
    step();
    valid = 1'b0;
    sb.delete();
    chk("drop_level",   level, 0);
    chk("drop_ur",      underrun, 0);
    chk("drop_en",      dac_en, 0);
    chk("drop_data",    dac_data, 0);
    chk("drop_sel",     dac_sel, 0);
    chk("drop_running", running, 0);
    chk("drop_ready",   ready, 0);
    step();
    step();
    chk("idle_level", level, 0);

    en = 1'b1;
    step();
    send(16'h1234, 16'hFFFC, w);
    chk("settle_push_level", level, 1);
    k = 0;
    while (!running && k < 200) begin
      step();
      k++;
    end
    chk("rerun", running, 1);
    check_tick(1'b1, 1'b0);
    check_tick(1'b0, 1'b1);
    chk("replay_ch1_val", last_pair[2*OUT-1:OUT], 14'h048D);

    rst = 1'b1;
    step();
    chk("mid_rst_en",    dac_en, 0);
    chk("mid_rst_run",   running, 0);
    chk("mid_rst_data",  dac_data, 0);
    chk("mid_rst_ur",    underrun, 0);
    chk("mid_rst_ready", ready, 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
